led_blink_multi: RTL and testbench

- Parametrised successor to the single free-running LED blinker.
- Drives CHANNELS independent LED outputs from one shared free-running counter.
- Per-channel mode (OFF/ON/BLINK/BREATHE) and rate, written over a valid/ready config port.
- Sits behind the top-level pin wrapper; the LED vector maps onto dedicated outputs.

---
 rtl/led_pkg.sv | 17 +
 rtl/led_blink_multi_if.sv | 32 +++
 rtl/led_chan.sv | 92 +++++++++
 rtl/led_blink_multi.sv | 64 ++++++
 tb/tb_led_blink_multi.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the multi-channel LED blinker.
// Mode encoding matches the cfg_mode field of the config port.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_t;

  // Channel-select width; a single channel still needs one select bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_blink_multi_if.sv
// Config write port of led_blink_multi: valid/ready handshake carrying
// target channel, mode and rate. The block is the slave side.
interface led_blink_multi_if
  import led_pkg::*;
#(
  parameter int unsigned CH_W   = 2,
  parameter int unsigned RATE_W = 4
);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  led_mode_t         cfg_mode;
  logic [RATE_W-1:0] cfg_rate;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_mode,
    output cfg_rate,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_mode,
    input  cfg_rate,
    output cfg_ready
  );

endinterface

// File: rtl/led_chan.sv
// One LED channel: holds mode/rate/phase and produces the registered LED bit
// from its local time t = cnt - phase.
// Optional macro LED_BREATHE_EN: enables the PWM triangle (BREATHE) mode;
// without it mode 3 behaves as BLINK and no PWM compare exists.
module led_chan
  import led_pkg::*;
#(
  parameter int unsigned CNT_W  = 26,
  parameter int unsigned RATE_W = 4,
  parameter int unsigned PWM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              wr,
  input  led_mode_t         mode,
  input  logic [RATE_W-1:0] rate,
  output logic              led
);

  localparam int unsigned IDX_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  led_mode_t         mode_q, mode_eff;
  logic [RATE_W-1:0] rate_q, rate_eff;
  logic [CNT_W-1:0]  phase_q, phase_eff;
  logic [CNT_W-1:0]  t;
  logic [IDX_W-1:0]  b;
  logic              blink;
  logic              led_d, led_q;

`ifdef LED_BREATHE_EN
  logic [PWM_W:0]   d;
  logic [PWM_W-1:0] duty;
  logic             pwm;
`endif

  // A write is folded in during its own cycle, so the new waveform starts at
  // t=0 and shows on led one cycle after acceptance.
  always_comb begin
    mode_eff  = wr ? mode : mode_q;
    rate_eff  = wr ? rate : rate_q;
    phase_eff = wr ? cnt  : phase_q;
    t         = cnt - phase_eff;
    b         = IDX_W'(CNT_W - 1) - IDX_W'(rate_eff);
    blink     = ~t[b];
  end

`ifdef LED_BREATHE_EN
  // Triangle duty from the bits below the blink bit, compared with the fast bits.
  always_comb begin
    d    = t[b -: PWM_W+1];
    duty = d[PWM_W] ? ~d[PWM_W-1:0] : d[PWM_W-1:0];
    pwm  = (t[PWM_W-1:0] < duty);
  end
`endif

  // Mode decode to the next LED value.
  always_comb begin
    led_d = 1'b0;
    case (mode_eff)
      LED_OFF:     led_d = 1'b0;
      LED_ON:      led_d = 1'b1;
      LED_BLINK:   led_d = blink;
`ifdef LED_BREATHE_EN
      LED_BREATHE: led_d = pwm;
`else
      LED_BREATHE: led_d = blink;
`endif
      default:     led_d = 1'b0;
    endcase
  end

  // Channel state and registered LED output.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= LED_OFF;
      rate_q  <= '0;
      phase_q <= '0;
      led_q   <= 1'b0;
    end else begin
      if (wr) begin
        mode_q  <= mode;
        rate_q  <= rate;
        phase_q <= cnt;
      end
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker: one shared free-running counter, a valid/ready
// config port and CHANNELS independent led_chan instances.
// Optional macro LED_BREATHE_EN (used in led_chan): enables BREATHE mode.
module led_blink_multi
  import led_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 26,
  parameter int unsigned RATE_W   = 4,
  parameter int unsigned PWM_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  led_blink_multi_if.slave    cfg,
  output logic [CHANNELS-1:0] led,
  output logic                wrap
);

  localparam int unsigned CH_W = ch_width(CHANNELS);

  logic [CNT_W-1:0] cnt_q;
  logic             wrap_q;
  logic             ready_q;
  logic             accept;

  assign accept        = cfg.cfg_valid && ready_q;
  assign cfg.cfg_ready = ready_q;
  assign wrap          = wrap_q;

  // Shared counter, wrap pulse aligned with cnt==0, and the one-cycle
  // ready gap after each accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_q + CNT_W'(1);
      wrap_q  <= &cnt_q;
      ready_q <= ~accept;
    end
  end

  // Channel decode; selects beyond CHANNELS match no channel and are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic wr;
    assign wr = accept && (cfg.cfg_ch == CH_W'(i));

    led_chan #(
      .CNT_W  (CNT_W),
      .RATE_W (RATE_W),
      .PWM_W  (PWM_W)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .cnt  (cnt_q),
      .wr   (wr),
      .mode (cfg.cfg_mode),
      .rate (cfg.cfg_rate),
      .led  (led[i])
    );
  end

endmodule

// File: tb/tb_led_blink_multi.sv
// Directed self-checking bench for led_blink_multi (CNT_W=12, PWM_W=4, RATE_W=2).
// A second 5-channel instance exercises an out-of-range channel select.
module tb_led_blink_multi;
  import led_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] led;
  logic       wrap;
  logic [4:0] led5;
  logic       wrap5;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    int         due;
    logic [3:0] mask;
    logic [3:0] led;
    logic       chk_ready;
    logic       ready;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];

  led_blink_multi_if #(.CH_W(2), .RATE_W(2)) cfg ();
  led_blink_multi_if #(.CH_W(3), .RATE_W(2)) cfg5 ();

  led_blink_multi #(
    .CHANNELS (4),
    .CNT_W    (12),
    .RATE_W   (2),
    .PWM_W    (4)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .cfg  (cfg),
    .led  (led),
    .wrap (wrap)
  );

  led_blink_multi #(
    .CHANNELS (5),
    .CNT_W    (12),
    .RATE_W   (2),
    .PWM_W    (4)
  ) u_dut5 (
    .clk  (clk),
    .rst  (rst),
    .cfg  (cfg5),
    .led  (led5),
    .wrap (wrap5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance to the next falling edge and compare every expectation due now.
  task automatic step();
    exp_t  e;
    string tg;
    int    n;
    @(negedge clk);
    cyc++;
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      e  = sb.pop_front();
      tg = sb_tag.pop_front();
      if (e.due == cyc) begin
        if (e.chk_ready) chk({tg, "_ready"}, 32'(cfg.cfg_ready), 32'(e.ready));
        if (e.mask != 4'h0) chk({tg, "_led"}, 32'(led & e.mask), 32'(e.led & e.mask));
      end else if (e.due < cyc) begin
        chk({tg, "_stale"}, 32'(e.due), 32'(cyc));
      end else begin
        sb.push_back(e);
        sb_tag.push_back(tg);
      end
    end
  endtask

  task automatic push(input string tag, input int due, input logic [3:0] mask,
                      input logic [3:0] expled, input logic chk_rdy, input logic rdy);
    sb.push_back('{due: due, mask: mask, led: expled, chk_ready: chk_rdy, ready: rdy});
    sb_tag.push_back(tag);
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input led_mode_t mode,
                       input logic [1:0] rate);
    cfg.cfg_valid = v;
    cfg.cfg_ch    = ch;
    cfg.cfg_mode  = mode;
    cfg.cfg_rate  = rate;
  endtask

  // Issue one write, waiting a bounded time for ready; expectations for the
  // cycle after acceptance and the ready return go to the scoreboard.
  task automatic wr4(input string tag, input logic [1:0] ch, input led_mode_t mode,
                     input logic [1:0] rate, input logic [3:0] mask,
                     input logic [3:0] expled, output int acc);
    int k;
    k = 0;
    drive(1'b1, ch, mode, rate);
    while (!cfg.cfg_ready && k < 8) begin
      step();
      k++;
    end
    chk({tag, "_ready_wait"}, 32'(cfg.cfg_ready), 32'd1);
    acc = cyc;
    push(tag, acc + 1, mask, expled, 1'b1, 1'b0);
    push({tag, "_back"}, acc + 2, 4'h0, 4'h0, 1'b1, 1'b1);
    step();
    cfg.cfg_valid = 1'b0;
  endtask

  int         acc0, acc1, acc2;
  int         wrap_cnt, wrap_at, err0, err2, hi_cnt, exp_cnt;
  logic       e0, e2;
  logic [3:0] first3;

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, LED_OFF, 2'd0);
    cfg5.cfg_valid = 1'b0;
    cfg5.cfg_ch    = 3'd0;
    cfg5.cfg_mode  = LED_OFF;
    cfg5.cfg_rate  = 2'd0;
    repeat (3) step();

    // Reset state, idle, and a single wrap after 4096 cycles.
    rst      = 1'b0;
    wrap_cnt = 0;
    wrap_at  = -1;
    for (int i = 0; i < 4200; i++) begin
      if (i > 0) step();
      if (i < 20) begin
        chk("idle_led", 32'(led), 32'd0);
        chk("idle_ready", 32'(cfg.cfg_ready), 32'd1);
        chk("idle_wrap", 32'(wrap), 32'd0);
      end
      if (wrap) begin
        wrap_cnt++;
        wrap_at = i;
      end
    end
    chk("wrap_count", 32'(wrap_cnt), 32'd1);
    chk("wrap_cycle", 32'(wrap_at), 32'd4096);
    chk("idle_led5", 32'(led5), 32'd0);

    // ON then OFF on channel 1.
    wr4("ch1_on", 2'd1, LED_ON, 2'd0, 4'hF, 4'b0010, acc0);
    wr4("ch1_off", 2'd1, LED_OFF, 2'd0, 4'hF, 4'b0000, acc0);
    step();

    // BLINK on ch0, then ch2 128 cycles later.
    wr4("ch0_blink", 2'd0, LED_BLINK, 2'd3, 4'hF, 4'b0001, acc0);
    repeat (127) step();
    wr4("ch2_blink", 2'd2, LED_BLINK, 2'd3, 4'hF, 4'b0101, acc2);
    chk("ch2_accept_offset", 32'(acc2 - acc0), 32'd128);
    err0 = 0;
    err2 = 0;
    for (int j = 1; j <= 600; j++) begin
      if (j > 1) step();
      e0 = (((127 + j) % 512) < 256);
      e2 = (((j - 1) % 512) < 256);
      if (led[0] !== e0) err0++;
      if (led[2] !== e2) err2++;
    end
    chk("ch0_undisturbed", 32'(err0), 32'd0);
    chk("ch2_blink_wave", 32'(err2), 32'd0);

    // Valid held across three writes; only alternate cycles are accepted.
    step();
    chk("b2b_start_ready", 32'(cfg.cfg_ready), 32'd1);
    acc1 = cyc;
    drive(1'b1, 2'd1, LED_ON, 2'd0);
    push("b2b_c1", acc1 + 1, 4'b1010, 4'b0010, 1'b1, 1'b0);
    step();
    drive(1'b1, 2'd3, LED_ON, 2'd0);
    push("b2b_c2", acc1 + 2, 4'b1000, 4'b0000, 1'b1, 1'b1);
    step();
    drive(1'b1, 2'd2, LED_OFF, 2'd0);
    push("b2b_c3", acc1 + 3, 4'b1100, 4'b0000, 1'b1, 1'b0);
    step();
    drive(1'b1, 2'd3, LED_ON, 2'd0);
    push("b2b_c4", acc1 + 4, 4'b1000, 4'b0000, 1'b1, 1'b1);
    step();
    drive(1'b1, 2'd0, LED_OFF, 2'd0);
    push("b2b_c5", acc1 + 5, 4'hF, 4'b0010, 1'b1, 1'b0);
    step();
    cfg.cfg_valid = 1'b0;
    push("b2b_c6", acc1 + 6, 4'hF, 4'b0010, 1'b1, 1'b1);
    step();
    step();

    // BREATHE on ch3: on-count per 16-cycle window.
`ifdef LED_BREATHE_EN
    first3 = 4'b0000;
`else
    first3 = 4'b1000;
`endif
    wr4("ch3_breathe", 2'd3, LED_BREATHE, 2'd3, 4'b1000, first3, acc0);
    for (int w = 0; w < 32; w++) begin
      hi_cnt = 0;
      for (int k = 0; k < 16; k++) begin
        if (!(w == 0 && k == 0)) step();
        if (led[3]) hi_cnt++;
      end
`ifdef LED_BREATHE_EN
      exp_cnt = (w < 16) ? w : 31 - w;
`else
      exp_cnt = (w < 16) ? 16 : 0;
`endif
      chk($sformatf("ch3_window%0d", w), 32'(hi_cnt), 32'(exp_cnt));
    end

    // Identical rewrite restarts the waveform.
    wr4("ch3_blink", 2'd3, LED_BLINK, 2'd3, 4'b1000, 4'b1000, acc0);
    repeat (100) step();
    wr4("ch3_rewrite", 2'd3, LED_BLINK, 2'd3, 4'b1000, 4'b1000, acc2);
    repeat (199) step();
    chk("ch3_restart_high", 32'(led[3]), 32'd1);
    repeat (57) step();
    chk("ch3_restart_low", 32'(led[3]), 32'd0);

    // Out-of-range channel on the 5-channel instance.
    cfg5.cfg_valid = 1'b1;
    cfg5.cfg_ch    = 3'd0;
    cfg5.cfg_mode  = LED_ON;
    cfg5.cfg_rate  = 2'd0;
    chk("oor_pre_ready", 32'(cfg5.cfg_ready), 32'd1);
    step();
    cfg5.cfg_valid = 1'b0;
    chk("oor_ch0_on_led", 32'(led5), 32'd1);
    step();
    chk("oor_pre_ready_back", 32'(cfg5.cfg_ready), 32'd1);
    cfg5.cfg_valid = 1'b1;
    cfg5.cfg_ch    = 3'd5;
    cfg5.cfg_mode  = LED_BLINK;
    cfg5.cfg_rate  = 2'd3;
    step();
    cfg5.cfg_valid = 1'b0;
    chk("oor_ready_low", 32'(cfg5.cfg_ready), 32'd0);
    chk("oor_led_same", 32'(led5), 32'd1);
    step();
    chk("oor_ready_back", 32'(cfg5.cfg_ready), 32'd1);
    repeat (300) step();
    chk("oor_led_later", 32'(led5), 32'd1);

    // Reset mid-operation with a simultaneous write.
    chk("pre_reset_led1", 32'(led[1]), 32'd1);
    rst = 1'b1;
    drive(1'b1, 2'd3, LED_ON, 2'd0);
    step();
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_ready", 32'(cfg.cfg_ready), 32'd1);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_led5", 32'(led5), 32'd0);
    rst = 1'b0;
    cfg.cfg_valid = 1'b0;
    repeat (3) step();
    chk("rst_write_dropped", 32'(led), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
